// File: rtl/arb_m2_if.sv
// Request/ack/response memory-bus port shared by both masters and the slave side of arb_m2.
// "master" is the side that issues requests; "slave" is the side that accepts them.
interface arb_m2_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              resp;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/arb_m2.sv
// Two-master to one-slave round-robin arbiter with grant lock until ack.
// Outstanding read ids are queued in order so each slave response returns to its issuer.
module arb_m2 #(
    parameter int unsigned RD_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    arb_m2_if.slave  m0,
    arb_m2_if.slave  m1,
    arb_m2_if.master s
);
    localparam int unsigned PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e         lock_q;
    logic                lock_id_q;
    logic                rr_last_q;
    logic [RD_DEPTH-1:0] rd_id_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic fifo_full_c;
    logic gnt_vld_c;
    logic gnt_id_c;
    logic accept_c;
    logic push_c;
    logic pop_c;
    logic head_id_c;
    logic m0_resp_c;
    logic m1_resp_c;

    assign fifo_full_c = (cnt_q == CNT_W'(RD_DEPTH));

    // Grant selection; a full read-id queue blocks writes as well as reads.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_id_c  = 1'b0;
        if (rst_ni && !fifo_full_c) begin
            if (lock_q == LOCKED) begin
                gnt_vld_c = 1'b1;
                gnt_id_c  = lock_id_q;
            end else if (m0.req && m1.req) begin
                gnt_vld_c = 1'b1;
                gnt_id_c  = !rr_last_q;
            end else if (m0.req || m1.req) begin
                gnt_vld_c = 1'b1;
                gnt_id_c  = m1.req;
            end
        end
    end

    // Present the granted master to the slave; nothing when idle.
    always_comb begin
        s.req   = 1'b0;
        s.we    = 1'b0;
        s.addr  = '0;
        s.be    = '0;
        s.wdata = '0;
        if (gnt_vld_c) begin
            if (gnt_id_c) begin
                s.req   = m1.req;
                s.we    = m1.we;
                s.addr  = m1.addr;
                s.be    = m1.be;
                s.wdata = m1.wdata;
            end else begin
                s.req   = m0.req;
                s.we    = m0.we;
                s.addr  = m0.addr;
                s.be    = m0.be;
                s.wdata = m0.wdata;
            end
        end
    end

    assign accept_c  = s.req && s.ack;
    assign push_c    = accept_c && !s.we;
    assign pop_c     = rst_ni && s.resp && (cnt_q != '0);
    assign head_id_c = rd_id_q[rd_ptr_q];

    assign m0.ack   = gnt_vld_c && !gnt_id_c && s.ack;
    assign m1.ack   = gnt_vld_c &&  gnt_id_c && s.ack;
    assign m0_resp_c = pop_c && !head_id_c;
    assign m1_resp_c = pop_c &&  head_id_c;
    assign m0.resp  = m0_resp_c;
    assign m1.resp  = m1_resp_c;
    assign m0.rdata = m0_resp_c ? s.rdata : '0;
    assign m1.rdata = m1_resp_c ? s.rdata : '0;

    // Lock state, round-robin history and read-id queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= UNLOCKED;
            lock_id_q <= 1'b0;
            rr_last_q <= 1'b1;
            rd_id_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (lock_q == UNLOCKED) begin
                if (gnt_vld_c && !s.ack) begin
                    lock_q    <= LOCKED;
                    lock_id_q <= gnt_id_c;
                end
            end else if (s.ack) begin
                lock_q <= UNLOCKED;
            end

            if (accept_c) begin
                rr_last_q <= gnt_id_c;
            end

            if (push_c) begin
                rd_id_q[wr_ptr_q] <= gnt_id_c;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            if (push_c && !pop_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_arb_m2.sv
// Self-checking bench for arb_m2: directed scenarios followed by a randomized run
// checked against a queue-based reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_arb_m2;
    localparam int unsigned RD_DEPTH = 4;
    localparam int unsigned N_RAND   = 3000;

    logic clk_i;
    logic rst_ni;

    arb_m2_if m0_if ();
    arb_m2_if m1_if ();
    arb_m2_if s_if ();

    arb_m2 #(.RD_DEPTH(RD_DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model state
    bit          mdl_lock;
    bit          mdl_lock_id;
    bit          mdl_rr_last;
    bit          mdl_q[$];

    // Randomized master transactions (held until acked)
    logic        pend[2];
    logic        pwe[2];
    logic [31:0] paddr[2];
    logic [3:0]  pbe[2];
    logic [31:0] pwd[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {s_req, m0_ack, m1_ack, m0_resp, m1_resp}
    function automatic logic [4:0] ctl();
        return {s_if.req, m0_if.ack, m1_if.ack, m0_if.resp, m1_if.resp};
    endfunction

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, 64'(ctl()), 64'(exp));
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic set_m(input int idx, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        if (idx == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.be = be; m0_if.wdata = wd;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.be = be; m1_if.wdata = wd;
        end
    endtask

    task automatic set_s(input logic ack, input logic resp, input logic [31:0] rdata);
        s_if.ack = ack; s_if.resp = resp; s_if.rdata = rdata;
    endtask

    task automatic idle();
        set_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_s(1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  exp_ctl;
        logic [31:0] rd;
        logic        gv;
        logic        gid;
        logic        sa;
        logic        sr;
        logic        pop;
        logic        hd;

        n_cmp = 0;
        n_err = 0;
        rst_ni = 1'b0;
        idle();

        // Outputs stay 0 in reset even with active inputs
        set_m(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        set_s(1'b1, 1'b1, 32'h55);
        repeat (2) @(posedge clk_i);
        #1; settle();
        chk_ctl("reset_ctl", 5'b00000);
        chk32("reset_saddr", s_if.addr, 32'h0);
        idle();
        tick();
        rst_ni = 1'b1;
        tick();

        // Single read from m0
        set_m(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        set_s(1'b1, 1'b0, 32'h0);
        settle();
        chk_ctl("single_rd_ack", 5'b11000);
        chk32("single_rd_saddr", s_if.addr, 32'h100);
        tick();
        idle();
        settle();
        chk_ctl("single_rd_gap", 5'b00000);
        tick();
        set_s(1'b0, 1'b1, 32'hDEADBEEF);
        settle();
        chk_ctl("single_rd_resp", 5'b00010);
        chk32("single_rd_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
        chk32("single_rd_m1_rdata", m1_if.rdata, 32'h0);
        tick();

        // Lock: m1 write held for 3 un-acked cycles while m0 also requests
        idle();
        set_m(0, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b1, 32'h300, 4'h3, 32'hCAFE);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk_ctl("lock_hold_ctl", 5'b10000);
            chk32("lock_hold_saddr", s_if.addr, 32'h300);
            tick();
        end
        set_s(1'b1, 1'b0, 32'h0);
        settle();
        chk_ctl("lock_release_ctl", 5'b10100);
        chk32("lock_release_wdata", s_if.wdata, 32'hCAFE);
        tick();
        set_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk_ctl("lock_next_m0", 5'b11000);
        chk32("lock_next_saddr", s_if.addr, 32'h200);
        tick();
        idle();
        set_s(1'b0, 1'b1, 32'h12345678);
        settle();
        chk_ctl("lock_m0_resp", 5'b00010);
        chk32("lock_m0_rdata", m0_if.rdata, 32'h12345678);
        tick();

        // Full read-id queue blocks further grants
        idle();
        set_m(0, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
        set_s(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk_ctl("full_fill", 5'b11000);
            tick();
        end
        settle();
        chk_ctl("full_block", 5'b00000);
        tick();
        set_s(1'b1, 1'b1, 32'hA5A5A5A5);
        settle();
        chk_ctl("full_pop_still_blocked", 5'b00010);
        tick();
        set_s(1'b1, 1'b0, 32'h0);
        settle();
        chk_ctl("full_reopen", 5'b11000);
        tick();
        set_s(1'b1, 1'b1, 32'h1);
        settle();
        chk_ctl("full_pop2", 5'b00010);
        tick();

        // Concurrent push (m1 read) and pop at count 3
        set_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
        set_s(1'b1, 1'b1, 32'h2);
        settle();
        chk_ctl("pushpop_ctl", 5'b10110);
        chk32("pushpop_rdata", m0_if.rdata, 32'h2);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            set_s(1'b0, 1'b1, 32'h10 + 32'(k));
            settle();
            exp_ctl = (k < 2) ? 5'b00010 : ((k == 2) ? 5'b00001 : 5'b00000);
            chk_ctl("pushpop_drain", exp_ctl);
            tick();
        end

        // Reset with two reads outstanding
        idle();
        set_m(0, 1'b1, 1'b0, 32'h600, 4'hF, 32'h0);
        set_s(1'b1, 1'b0, 32'h0);
        settle();
        chk_ctl("rstmid_rd0", 5'b11000);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h700, 4'hF, 32'h0);
        settle();
        chk_ctl("rstmid_rd1", 5'b10100);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h800, 4'hF, 32'h0);
        set_s(1'b1, 1'b1, 32'h77);
        rst_ni = 1'b0;
        settle();
        chk_ctl("rstmid_outputs", 5'b00000);
        chk32("rstmid_m1_rdata", m1_if.rdata, 32'h0);
        tick();
        idle();
        rst_ni = 1'b1;
        set_s(1'b0, 1'b1, 32'h88);
        settle();
        chk_ctl("rstmid_stray_resp", 5'b00000);
        tick();

        // Round-robin from reset state: both masters request reads continuously
        for (int i = 0; i < 8; i++) begin
            set_m(0, 1'b1, 1'b0, 32'h1000 + 32'(i), 4'hF, 32'h0);
            set_m(1, 1'b1, 1'b0, 32'h2000 + 32'(i), 4'hF, 32'h0);
            set_s(1'b1, (i > 0), 32'hB000 + 32'(i));
            settle();
            exp_ctl = (i % 2 == 0) ? 5'b11000 : 5'b10100;
            if (i > 0) exp_ctl = exp_ctl | (((i - 1) % 2 == 0) ? 5'b00010 : 5'b00001);
            chk_ctl("rr_ctl", exp_ctl);
            if (i > 0) begin
                chk32("rr_rdata", ((i - 1) % 2 == 0) ? m0_if.rdata : m1_if.rdata, 32'hB000 + 32'(i));
            end
            tick();
        end
        idle();
        set_s(1'b0, 1'b1, 32'hB008);
        settle();
        chk_ctl("rr_last_resp", 5'b00001);
        chk32("rr_last_rdata", m1_if.rdata, 32'hB008);
        tick();

        // Randomized run against the reference model
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        mdl_lock    = 1'b0;
        mdl_lock_id = 1'b0;
        mdl_rr_last = 1'b1;
        mdl_q.delete();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pbe[i] = '0; pwd[i] = '0;
        end
        for (int c = 0; c < int'(N_RAND); c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    pwe[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = $urandom;
                    pbe[i]   = 4'($urandom);
                    pwd[i]   = $urandom;
                end
            end
            set_m(0, pend[0], pwe[0], paddr[0], pbe[0], pwd[0]);
            set_m(1, pend[1], pwe[1], paddr[1], pbe[1], pwd[1]);
            sa = 1'($urandom_range(0, 1));
            sr = ($urandom_range(0, 2) == 0);
            rd = $urandom;
            set_s(sa, sr, rd);

            gv  = 1'b0;
            gid = 1'b0;
            if (mdl_q.size() < RD_DEPTH) begin
                if (mdl_lock) begin
                    gv = 1'b1; gid = mdl_lock_id;
                end else if (pend[0] && pend[1]) begin
                    gv = 1'b1; gid = !mdl_rr_last;
                end else if (pend[0] || pend[1]) begin
                    gv = 1'b1; gid = pend[1];
                end
            end
            pop = sr && (mdl_q.size() > 0);
            hd  = pop ? mdl_q[0] : 1'b0;

            settle();
            exp_ctl = {gv, gv && sa && !gid, gv && sa && gid, pop && !hd, pop && hd};
            chk_ctl("rnd_ctl", exp_ctl);
            chk32("rnd_saddr", s_if.addr, gv ? paddr[gid] : 32'h0);
            chk("rnd_sdata", 64'({s_if.we, s_if.be, s_if.wdata}),
                gv ? 64'({pwe[gid], pbe[gid], pwd[gid]}) : 64'h0);
            chk("rnd_rdata", {m0_if.rdata, m1_if.rdata},
                pop ? (hd ? {32'h0, rd} : {rd, 32'h0}) : 64'h0);

            if (pop) void'(mdl_q.pop_front());
            if (gv && sa) begin
                mdl_rr_last = gid;
                mdl_lock    = 1'b0;
                if (!pwe[gid]) mdl_q.push_back(gid);
                pend[gid] = 1'b0;
            end else if (gv) begin
                mdl_lock    = 1'b1;
                mdl_lock_id = gid;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
